// File: rtl/multi_ctrl_fsm.sv
// multi_ctrl_fsm: multicycle MIPS control unit with memory-ready stalls, sticky illegal-op flag and retire counter
module multi_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             RegWrite,
  output logic             PCEn,
  output logic             next_ins,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t cur, nxt;
  logic   is_sw, op_bad, retire;
  // only the lw/sw distinction is needed after DECODE, so only that bit of op is latched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= FETCH;
      is_sw       <= 1'b0;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) is_sw <= (op == 6'b101011);
      if (op_bad) illegal_op <= 1'b1;
      if (retire) instr_count <= instr_count + ONE;
    end
  end
  always_comb begin
    nxt      = FETCH;
    op_bad   = 1'b0;
    next_ins = 1'b0;
    MemToReg = 1'b0;
    RegDst   = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUOp    = 2'b00;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    case (cur)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000:            nxt = EXECUTE;
          6'b000100:            nxt = BRANCH;
          6'b001000:            nxt = ADDIEXEC;
          6'b000010:            nxt = JUMP;
          default: begin
            op_bad   = 1'b1;
            next_ins = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = is_sw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD = 1'b1;
        nxt  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        next_ins = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        next_ins = mem_ready;
        nxt      = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        next_ins = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        Branch   = 1'b1;
        next_ins = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        next_ins = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        PCWrite  = 1'b1;
        next_ins = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  assign retire = next_ins & ~op_bad;
  assign PCEn   = PCWrite | (Branch & zero);
  assign state  = cur;
endmodule
